fwd_scoreboard: RTL

Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core. It takes the source registers of the instruction in ID and tracks the destinations of every in-flight instruction in a shift register FWD_DEPTH slots deep. It produces registered per-operand forward selects that are aligned with the instruction once it reaches EX. It also produces a combinational stall request for load-use hazards and a saturating stall-cycle counter for performance checks.

---
 rtl/fwd_scoreboard.sv | 63 ++++++
 1 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forward selects, load-use stall and saturating stall count over an in-flight destination shift register
module fwd_scoreboard #(
  parameter  int REG_AW    = 5,
  parameter  int NUM_SRC   = 2,
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_LAT  = 1,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ID_Valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] ID_RS_i,
  input  logic [REG_AW-1:0]         ID_RD_i,
  input  logic                      ID_RegWrite_i,
  input  logic                      ID_MemRead_i,
  input  logic                      Flush_i,
  output logic                      Stall_o,
  output logic [NUM_SRC*SEL_W-1:0]  Forward_o,
  output logic [15:0]               StallCount_o
);
  logic [FWD_DEPTH-1:0] v, w, ld;
  logic [REG_AW-1:0] rd [FWD_DEPTH];
  logic [NUM_SRC-1:0][FWD_DEPTH-1:0] hit;
  logic [NUM_SRC*SEL_W-1:0] sel;
  logic [NUM_SRC-1:0] haz;
  logic issue;
  for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
    for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_slot
      assign hit[n][k] = v[k] && w[k] && rd[k] == ID_RS_i[n*REG_AW +: REG_AW] && |ID_RS_i[n*REG_AW +: REG_AW];
    end
  end
  always_comb begin
    sel = '0;
    haz = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        sel[n*SEL_W +: SEL_W] = hit[n][k] ? SEL_W'(k + 1) : sel[n*SEL_W +: SEL_W];
        haz[n] = hit[n][k] ? ld[k] && k < LOAD_LAT : haz[n];
      end
    end
  end
  assign Stall_o = ID_Valid_i && !Flush_i && |haz;
  assign issue = ID_Valid_i && !Flush_i && !Stall_o;
  always_ff @(posedge clk_i) begin
    for (int k = FWD_DEPTH - 1; k > 0; k--) begin
      v[k] <= v[k-1];
      w[k] <= w[k-1];
      ld[k] <= ld[k-1];
      rd[k] <= rd[k-1];
    end
    v[0] <= issue;
    w[0] <= ID_RegWrite_i;
    ld[0] <= ID_MemRead_i;
    rd[0] <= ID_RD_i;
    Forward_o <= issue ? sel : '0;
    StallCount_o <= StallCount_o + 16'(Stall_o && ~&StallCount_o);
    if (rst_i) begin
      v <= '0;
      Forward_o <= '0;
      StallCount_o <= '0;
    end
  end
endmodule
